// File: rtl/hf_tans_recoder.sv
// -----------------------------------------------------------------------------
// hf_tans_recoder
//
// Streaming recoder from 2-bit Huffman symbol codes (A, B, C) to a tANS
// bitstream with table size L = 16 and fixed frequencies f_A = 8, f_B = 6,
// f_C = 2. One symbol is accepted per clock. For each symbol, 0-3
// renormalisation bits are emitted together with a bit count.
//
// The true tANS state is x = 16 + s, where s is the 4-bit stored state. The
// spread table (slot 0..15) is:
//   A B A C A B A B A B A C A B A B
//
// Ports
//   PHI          clock, rising edge
//   RST          asynchronous, active-high reset
//   I_F          initial flag: the symbol on this edge starts from x = 16
//   i_stream     symbol code: 00 = A, 10 = B, 11 = C, anything else = idle
//   BTR          number of valid bits in o_stream (0-3)
//   o_stream     emitted bits, right-justified, unused upper bits zero
//   final_state  current stored state s, so the packer can flush it
//
// Configuration macro
//   HF_TANS_PIPE_EN  When defined, BTR and o_stream pass through one extra
//                    output register, giving 2-cycle latency. final_state
//                    timing is unchanged.
// -----------------------------------------------------------------------------
module hf_tans_recoder (
  input  logic       PHI,
  input  logic       RST,
  input  logic       I_F,
  input  logic [1:0] i_stream,
  output logic [1:0] BTR,
  output logic [2:0] o_stream,
  output logic [3:0] final_state
);

  logic [3:0] s_q, s_d;
  logic [1:0] btr_q, btr_d;
  logic [2:0] bits_q, bits_d;
  logic [3:0] s_cur;

  // The y-th B slot in the spread table: 1, 5, 7, 9, 13, 15.
  function automatic logic [3:0] b_slot(input logic [2:0] y);
    logic [3:0] slot;
    case (y)
      3'd0:    slot = 4'd1;
      3'd1:    slot = 4'd5;
      3'd2:    slot = 4'd7;
      3'd3:    slot = 4'd9;
      3'd4:    slot = 4'd13;
      3'd5:    slot = 4'd15;
      default: slot = 4'd0;
    endcase
    return slot;
  endfunction

  always_comb begin
    // I_F discards the stored state: pre-state x = 16, i.e. s = 0.
    s_cur  = I_F ? 4'd0 : s_q;
    s_d    = s_cur;
    btr_d  = 2'd0;
    bits_d = 3'd0;
    case (i_stream)
      2'b00: begin
        // A: x >> 1 = 8 + s[3:1], so y = s[3:1]; A slots are the even ones.
        btr_d  = 2'd1;
        bits_d = {2'b00, s_cur[0]};
        s_d    = {s_cur[3:1], 1'b0};
      end
      2'b10: begin
        if (!s_cur[3]) begin
          // B with x < 24: k = 1, x >> 1 = 8 + s[2:1], y = 2 + s[2:1].
          btr_d  = 2'd1;
          bits_d = {2'b00, s_cur[0]};
          s_d    = b_slot(3'd2 + {1'b0, s_cur[2:1]});
        end else begin
          // B with x >= 24: k = 2, x >> 2 = 6 + s[2], y = s[2].
          btr_d  = 2'd2;
          bits_d = {1'b0, s_cur[1:0]};
          s_d    = b_slot({2'b00, s_cur[2]});
        end
      end
      2'b11: begin
        // C: k = 3, x >> 3 = 2 + s[3], y = s[3]; C slots are 3 and 11.
        btr_d  = 2'd3;
        bits_d = s_cur[2:0];
        s_d    = {s_cur[3], 3'b011};
      end
      default: begin
        // Idle (including unknown codes): no bits; s holds unless I_F.
        btr_d  = 2'd0;
        bits_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge PHI or posedge RST) begin
    if (RST) begin
      s_q    <= 4'd0;
      btr_q  <= 2'd0;
      bits_q <= 3'd0;
    end else begin
      s_q    <= s_d;
      btr_q  <= btr_d;
      bits_q <= bits_d;
    end
  end

  assign final_state = s_q;

`ifdef HF_TANS_PIPE_EN
  // Extra output stage for BTR / o_stream only; state is not delayed.
  logic [1:0] btr_p_q;
  logic [2:0] bits_p_q;

  always_ff @(posedge PHI or posedge RST) begin
    if (RST) begin
      btr_p_q  <= 2'd0;
      bits_p_q <= 3'd0;
    end else begin
      btr_p_q  <= btr_q;
      bits_p_q <= bits_q;
    end
  end

  assign BTR      = btr_p_q;
  assign o_stream = bits_p_q;
`else
  assign BTR      = btr_q;
  assign o_stream = bits_q;
`endif

endmodule

// File: tb/tb_hf_tans_recoder.sv
// -----------------------------------------------------------------------------
// tb_hf_tans_recoder
//
// Self-checking bench for hf_tans_recoder. The reference model works on the
// true state x = 16 + s with plain arithmetic: it searches for k such that
// (x >> k) lies in [f, 2f), and walks the spread table to find the y-th slot
// of the symbol. Directed streams are followed by a randomized stream.
// -----------------------------------------------------------------------------
module tb_hf_tans_recoder;

  logic       PHI;
  logic       RST;
  logic       I_F;
  logic [1:0] i_stream;
  logic [1:0] BTR;
  logic [2:0] o_stream;
  logic [3:0] final_state;

  bit clk_run = 0;

  int checks = 0;
  int errors = 0;

  // Reference model state and the previous expected outputs (for the
  // optional extra output register).
  int m_s    = 0;
  int prev_k = 0;
  int prev_b = 0;

  // Spread table as symbol indices: 0 = A, 1 = B, 2 = C.
  int spread [16] = '{0, 1, 0, 2, 0, 1, 0, 1, 0, 1, 0, 2, 0, 1, 0, 1};

  hf_tans_recoder dut (
    .PHI         (PHI),
    .RST         (RST),
    .I_F         (I_F),
    .i_stream    (i_stream),
    .BTR         (BTR),
    .o_stream    (o_stream),
    .final_state (final_state)
  );

  initial begin
    PHI = 1'b0;
    wait (clk_run);
    forever #5 PHI = ~PHI;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", tag, obs, exp);
    end
  endtask

  // Reference model: returns bit count k and the emitted bits, updates m_s.
  task automatic model(input bit i_f, input logic [1:0] sym, output int k, output int b);
    int x, f, sidx, y, cnt;
    x = i_f ? 16 : 16 + m_s;
    k = 0;
    b = 0;
    case (sym)
      2'b00: begin f = 8; sidx = 0; end
      2'b10: begin f = 6; sidx = 1; end
      2'b11: begin f = 2; sidx = 2; end
      default: begin f = 0; sidx = -1; end
    endcase
    if (sidx < 0) begin
      if (i_f) m_s = 0;
    end else begin
      for (int kk = 0; kk < 5; kk++) begin
        if (((x >> kk) >= f) && ((x >> kk) < 2 * f)) begin
          k = kk;
          break;
        end
      end
      b = x & ((1 << k) - 1);
      y = (x >> k) - f;
      cnt = 0;
      for (int j = 0; j < 16; j++) begin
        if (spread[j] == sidx) begin
          if (cnt == y) m_s = j;
          cnt++;
        end
      end
    end
  endtask

  // One clock: drive on the falling edge, check 1 time unit after rising edge.
  task automatic step(input bit i_f, input logic [1:0] sym, input string tag);
    int k, b, ek, eb;
    @(negedge PHI);
    I_F      = i_f;
    i_stream = sym;
    model(i_f, sym, k, b);
    @(posedge PHI);
    #1;
`ifdef HF_TANS_PIPE_EN
    ek = prev_k;
    eb = prev_b;
`else
    ek = k;
    eb = b;
`endif
    prev_k = k;
    prev_b = b;
    $display("%s: I_F=%0b sym=%b -> BTR=%0d o_stream=%b final_state=%b",
             tag, i_f, sym, BTR, o_stream, final_state);
    check({tag, " BTR"}, {30'd0, BTR}, ek);
    check({tag, " o_stream"}, {29'd0, o_stream}, eb);
    check({tag, " final_state"}, {28'd0, final_state}, m_s);
  endtask

  // Asynchronous reset in the middle of a clock phase, checked before any edge.
  task automatic mid_reset(input string tag);
    #1;
    RST = 1'b1;
    #1;
    m_s    = 0;
    prev_k = 0;
    prev_b = 0;
    $display("%s: reset asserted -> BTR=%0d o_stream=%b final_state=%b",
             tag, BTR, o_stream, final_state);
    check({tag, " BTR"}, {30'd0, BTR}, 0);
    check({tag, " o_stream"}, {29'd0, o_stream}, 0);
    check({tag, " final_state"}, {28'd0, final_state}, 0);
    @(negedge PHI);
    RST      = 1'b0;
    I_F      = 1'b0;
    i_stream = 2'b01;
  endtask

  localparam logic [1:0] SA = 2'b00, SB = 2'b10, SC = 2'b11, SI = 2'b01;

  initial begin
    logic [1:0] s1 [8];
    logic [1:0] s2 [8];
    s1 = '{SB, SA, SA, SA, SC, SB, SA, SA};
    s2 = '{SA, SC, SB, SA, SA, SA, SB, SA};

    // Reset with no clock running.
    RST      = 1'b1;
    I_F      = 1'b0;
    i_stream = SI;
    #3;
    check("por BTR", {30'd0, BTR}, 0);
    check("por o_stream", {29'd0, o_stream}, 0);
    check("por final_state", {28'd0, final_state}, 0);
    RST = 1'b0;
    #1;
    clk_run = 1;

    for (int i = 0; i < 3; i++) step(1'b0, SI, "idle");

    // Stream B A A A C B A A, I_F on the first symbol.
    for (int i = 0; i < 8; i++) step(i == 0, s1[i], "stream1");
    check("stream1 end state", {28'd0, final_state}, 4'b1000);

    // Stream A C B A A A B A, I_F on the first symbol.
    for (int i = 0; i < 8; i++) step(i == 0, s2[i], "stream2");
    check("stream2 end state", {28'd0, final_state}, 4'b0000);

    // Idle insertion.
    step(1'b1, SB, "idle_ins");
    step(1'b0, SA, "idle_ins");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, SI, "idle_ins gap");
      check("idle held state", {28'd0, final_state}, 4'b0110);
    end
    step(1'b0, SA, "idle_ins");
    check("idle_ins end state", {28'd0, final_state}, 4'b0110);

    // Restart with I_F mid-stream.
    step(1'b1, SB, "restart");
    step(1'b0, SA, "restart");
    step(1'b0, SA, "restart");
    step(1'b1, SC, "restart");
    check("restart end state", {28'd0, final_state}, 4'b0011);

    // Reset mid-stream.
    step(1'b1, SA, "midrst");
    step(1'b0, SC, "midrst");
    mid_reset("midrst");
    step(1'b1, SA, "midrst");
    check("midrst end state", {28'd0, final_state}, 4'b0000);

    // I_F with idle clears the state.
    step(1'b0, SC, "ifidle");
    step(1'b1, SI, "ifidle");
    check("ifidle state", {28'd0, final_state}, 4'b0000);

    // Randomized stream.
    step(1'b1, SA, "rand");
    for (int i = 0; i < 400; i++) begin
      bit f;
      logic [1:0] sym;
      f   = ($urandom_range(0, 7) == 0);
      sym = 2'($urandom_range(0, 3));
      step(f, sym, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bound the whole run so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running, required finished");
    $fatal(1, "timeout");
  end

endmodule
